// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer.
//   ADDR_W         : width of every redirect address bus
//   STALL_W        : width of the stall vector (PC, IF, IFID, IDROB, ROB)
//   STALL_PC..ROB  : bit index of each stage inside the stall vector
//   DRAIN_W        : width of the post-flush drain counter (holds 1..7)
//   pctrl_state_e  : sequencer states, 2-bit encoding
//   stall_vec()    : turns per-stage stall requests into a thermometer vector
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int ADDR_W  = 32;
    localparam int STALL_W = 5;
    localparam int DRAIN_W = 3;

    localparam int STALL_PC    = 0;
    localparam int STALL_IF    = 1;
    localparam int STALL_IFID  = 2;
    localparam int STALL_IDROB = 3;
    localparam int STALL_ROB   = 4;

    typedef enum logic [1:0] {
        PCTRL_IDLE  = 2'd0,
        PCTRL_FLUSH = 2'd1,
        PCTRL_DRAIN = 2'd2
    } pctrl_state_e;

    // A stage that stalls must also hold every stage upstream of it, so the
    // result is always a run of ones starting at the PC bit.
    function automatic logic [STALL_W-1:0] stall_vec(input logic req_if,
                                                     input logic req_id,
                                                     input logic req_rob);
        logic [STALL_W-1:0] v;
        v              = '0;
        v[STALL_ROB]   = req_rob;
        v[STALL_IDROB] = req_rob | req_id;
        v[STALL_IFID]  = req_rob | req_id;
        v[STALL_IF]    = req_rob | req_id | req_if;
        v[STALL_PC]    = req_rob | req_id | req_if;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_redirect_arbiter.sv
// ---------------------------------------------------------------------------
// redirect_arbiter
// Combinational priority mux over the three redirect sources.
// Priority: exception > ERET > branch mispredict; losers are dropped.
//   exc_req / exc_handler_pc   : commit-time exception and its vector
//   eret_req / epc             : ERET and its return address
//   mispredict / mispredict_pc : branch redirect (already gated by caller)
//   req_valid / req_pc         : winning request and its target
// ---------------------------------------------------------------------------
module redirect_arbiter
    import pipe_ctrl_pkg::*;
(
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_handler_pc,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    input  logic              mispredict,
    input  logic [ADDR_W-1:0] mispredict_pc,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_pc
);

    // Fixed priority select of the redirect target.
    always_comb begin
        req_valid = 1'b0;
        req_pc    = '0;
        if (exc_req) begin
            req_valid = 1'b1;
            req_pc    = exc_handler_pc;
        end else if (eret_req) begin
            req_valid = 1'b1;
            req_pc    = epc;
        end else if (mispredict) begin
            req_valid = 1'b1;
            req_pc    = mispredict_pc;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush sequencer for PC, IF, IFID, IDROB and ROB.
//   clk, rst        : clock, synchronous active-low reset
//   stall_req_*     : per-stage stall requests (IF, ID, ROB)
//   mispredict(_pc) : branch redirect request and target
//   exc_req, exc_handler_pc, eret_req, epc : commit-time redirects
//   stall[4:0]      : PC, IF, IFID, IDROB, ROB stall enables
//   flush, flush_pc : one-cycle kill pulse with its redirect target
//   busy            : high while flushing or draining
// Optional build macro PIPE_CTRL_PERF_CNT_EN adds saturating counters
//   flush_count (FLUSH cycles) and stall_cycles (cycles with stall[3]=1).
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,parameter int CNT_WIDTH = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_req_if,
    input  logic               stall_req_id,
    input  logic               stall_req_rob,
    input  logic               mispredict,
    input  logic [ADDR_W-1:0]  mispredict_pc,
    input  logic               exc_req,
    input  logic [ADDR_W-1:0]  exc_handler_pc,
    input  logic               eret_req,
    input  logic [ADDR_W-1:0]  epc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [ADDR_W-1:0]  flush_pc,
    output logic               busy
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,output logic [CNT_WIDTH-1:0] flush_count,
    output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);

    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

    pctrl_state_e      state_q;
    logic              flush_q;
    logic              busy_q;
    logic [ADDR_W-1:0] flush_pc_q;
    logic [DRAIN_W-1:0] drain_q;

    logic              mispredict_en;
    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;

    // A mispredict seen while flushing or draining belongs to an instruction
    // that the flush has already killed, so only IDLE lets it through.
    assign mispredict_en = mispredict && (state_q == PCTRL_IDLE);

    redirect_arbiter u_arb (
        .exc_req        (exc_req),
        .exc_handler_pc (exc_handler_pc),
        .eret_req       (eret_req),
        .epc            (epc),
        .mispredict     (mispredict_en),
        .mispredict_pc  (mispredict_pc),
        .req_valid      (req_valid),
        .req_pc         (req_pc)
    );

    // Stall vector follows the requests directly, but a flushing pipeline
    // must not hold stale contents, and nothing stalls while in reset.
    always_comb begin
        stall = stall_vec(stall_req_if, stall_req_id, stall_req_rob);
        if (!rst || flush_q) begin
            stall = '0;
        end
    end

    // Sequencer: any accepted redirect produces a one-cycle flush, then a
    // drain window of DRAIN_CYCLES cycles. Outputs are registered alongside
    // the state so they line up with it exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= PCTRL_IDLE;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
            flush_pc_q <= '0;
            drain_q    <= '0;
        end else begin
            flush_q <= 1'b0;
            if (req_valid) begin
                // Any winning request, from any state, restarts the flush.
                state_q    <= PCTRL_FLUSH;
                flush_q    <= 1'b1;
                busy_q     <= 1'b1;
                flush_pc_q <= req_pc;
                if (state_q == PCTRL_FLUSH) begin
                    drain_q <= DRAIN_LOAD;
                end
            end else begin
                case (state_q)
                    PCTRL_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    PCTRL_FLUSH: begin
                        state_q <= PCTRL_DRAIN;
                        busy_q  <= 1'b1;
                        drain_q <= DRAIN_LOAD;
                    end
                    PCTRL_DRAIN: begin
                        if (drain_q == DRAIN_LAST) begin
                            state_q <= PCTRL_IDLE;
                            busy_q  <= 1'b0;
                        end
                        drain_q <= drain_q - DRAIN_LAST;
                    end
                    default: begin
                        state_q <= PCTRL_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign flush    = flush_q;
    assign flush_pc = flush_pc_q;
    assign busy     = busy_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] flush_count_q;
    logic [CNT_WIDTH-1:0] stall_cycles_q;

    // Saturating event counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flush_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (flush_q && !(&flush_count_q)) begin
                flush_count_q <= flush_count_q + CNT_ONE;
            end
            if (stall[STALL_IDROB] && !(&stall_cycles_q)) begin
                stall_cycles_q <= stall_cycles_q + CNT_ONE;
            end
        end
    end

    assign flush_count  = flush_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. The reference model tracks only how
// many cycles have passed since the last flush pulse and the last redirect
// target; busy, flush and mispredict acceptance all follow from that count.
// With PIPE_CTRL_PERF_CNT_EN defined the counters are exercised as well.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int DRAIN    = 2;
    localparam int IDLE_GAP = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_req_if = 1'b0, stall_req_id = 1'b0, stall_req_rob = 1'b0;
    logic        mispredict = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
    logic [31:0] mispredict_pc = '0, exc_handler_pc = '0, epc = '0;
    logic [4:0]  stall;
    logic        flush, busy;
    logic [31:0] flush_pc;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] flush_count, stall_cycles;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int          sinceFlush = IDLE_GAP;
    logic [31:0] pcModel    = '0;

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_req_if   (stall_req_if),
        .stall_req_id   (stall_req_id),
        .stall_req_rob  (stall_req_rob),
        .mispredict     (mispredict),
        .mispredict_pc  (mispredict_pc),
        .exc_req        (exc_req),
        .exc_handler_pc (exc_handler_pc),
        .eret_req       (eret_req),
        .epc            (epc),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .busy           (busy)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,.flush_count   (flush_count),
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Expected {stall, flush, busy, flush_pc} for the current cycle.
    function automatic logic [38:0] expOut();
        int         n;
        logic [4:0] st;
        n  = stall_req_rob ? 5 : stall_req_id ? 4 : stall_req_if ? 2 : 0;
        st = 5'((1 << n) - 1);
        if (!rst || sinceFlush == 0) st = '0;
        return {st, (sinceFlush == 0), (sinceFlush <= DRAIN), pcModel};
    endfunction

    task automatic applyStimulus(input logic rob, input logic id, input logic ifs,
                                 input logic mis, input logic [31:0] mpc,
                                 input logic exc, input logic [31:0] xpc,
                                 input logic eret, input logic [31:0] rpc);
        stall_req_rob  = rob;  stall_req_id = id;  stall_req_if = ifs;
        mispredict     = mis;  mispredict_pc  = mpc;
        exc_req        = exc;  exc_handler_pc = xpc;
        eret_req       = eret; epc            = rpc;
    endtask

    // Advance one clock and let the model absorb the inputs of that cycle.
    task automatic advance();
        bit busyNow;
        @(posedge clk);
        if (!rst) begin
            sinceFlush = IDLE_GAP;
            pcModel    = '0;
        end else begin
            busyNow = (sinceFlush <= DRAIN);
            if (exc_req) begin
                sinceFlush = 0; pcModel = exc_handler_pc;
            end else if (eret_req) begin
                sinceFlush = 0; pcModel = epc;
            end else if (mispredict && !busyNow) begin
                sinceFlush = 0; pcModel = mispredict_pc;
            end else if (sinceFlush < IDLE_GAP) begin
                sinceFlush++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(1, 1, 1, 1, 32'h1111_0000, 1, 32'h2222_0000, 1, 32'h3333_0000);
        advance();
        advance();
        #1;
        compared++;
        if ({stall, flush, busy, flush_pc} !== 39'd0 ||
            {stall, flush, busy, flush_pc} !== expOut()) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %h expected %h", {stall, flush, busy, flush_pc}, expOut());
        end
        rst = 1'b1;
        applyStimulus(0, 1, 0, 0, '0, 0, '0, 0, '0);
        #1;
        compared++;
        if (stall !== 5'b01111 || {stall, flush, busy, flush_pc} !== expOut()) begin
            mismatched++;
            $display("[TB] FAIL reset_release_stall: got %b expected 01111", stall);
        end
        advance();
        applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, '0);
        advance();
    endtask

    task automatic test_mispredict(input bit stallOn);
        logic [4:0] expF = 5'b00010;
        logic [4:0] expB = 5'b01110;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, stallOn, 0, (i == 0), 32'hbfc0_0100, 0, '0, 0, '0);
            #1;
            compared++;
            if ({stall, flush, busy, flush_pc} !== expOut() || flush !== expF[i] ||
                busy !== expB[i] || (i == 1 && flush_pc !== 32'hbfc0_0100)) begin
                mismatched++;
                $display("[TB] FAIL mispredict_c%0d: got %h expected %h", i,
                         {stall, flush, busy, flush_pc}, expOut());
            end
            advance();
        end
    endtask

    task automatic test_priority();
        int flushes = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, (i == 0), 32'h0000_4444, (i == 0), 32'hbfc0_0380,
                          (i == 0), 32'h0000_5555);
            #1;
            if (flush === 1'b1) flushes++;
            compared++;
            if ({stall, flush, busy, flush_pc} !== expOut() ||
                (i == 1 && flush_pc !== 32'hbfc0_0380)) begin
                mismatched++;
                $display("[TB] FAIL priority_c%0d: got %h expected %h", i,
                         {stall, flush, busy, flush_pc}, expOut());
            end
            advance();
        end
        compared++;
        if (flushes !== 1) begin
            mismatched++;
            $display("[TB] FAIL priority_flush_count: got %0d expected 1", flushes);
        end
    endtask

    task automatic test_preemption();
        logic [6:0] expF = 7'b0001010;
        logic [6:0] expB = 7'b0111110;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 0, (i == 0), 32'h8000_0000, 0, '0, (i == 2), 32'h8000_1234);
            #1;
            compared++;
            if ({stall, flush, busy, flush_pc} !== expOut() || flush !== expF[i] ||
                busy !== expB[i] || (i == 3 && flush_pc !== 32'h8000_1234)) begin
                mismatched++;
                $display("[TB] FAIL preemption_c%0d: got %h expected %h", i,
                         {stall, flush, busy, flush_pc}, expOut());
            end
            advance();
        end
    endtask

    task automatic test_drain_filter();
        int flushes;
        int holdLen [2] = '{4, 6};
        int expCnt  [2] = '{1, 2};
        for (int p = 0; p < 2; p++) begin
            flushes = 0;
            for (int i = 0; i < 9; i++) begin
                applyStimulus(0, 0, 0, (i < holdLen[p]), 32'h0000_1000 + 32'(i), 0, '0, 0, '0);
                #1;
                if (flush === 1'b1) flushes++;
                compared++;
                if ({stall, flush, busy, flush_pc} !== expOut()) begin
                    mismatched++;
                    $display("[TB] FAIL drain_filter_p%0d_c%0d: got %h expected %h", p, i,
                             {stall, flush, busy, flush_pc}, expOut());
                end
                advance();
            end
            compared++;
            if (flushes !== expCnt[p]) begin
                mismatched++;
                $display("[TB] FAIL drain_filter_count_p%0d: got %0d expected %0d",
                         p, flushes, expCnt[p]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3),
                          $urandom(), ($urandom_range(0, 99) < 8), $urandom(),
                          ($urandom_range(0, 99) < 8), $urandom());
            #1;
            compared++;
            if ({stall, flush, busy, flush_pc} !== expOut()) begin
                mismatched++;
                $display("[TB] FAIL random_c%0d: got %h expected %h", i,
                         {stall, flush, busy, flush_pc}, expOut());
            end
            advance();
        end
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, '0);
        for (int i = 0; i < DRAIN + 2; i++) advance();
    endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, '0);
        advance();
        rst = 1'b1;
        test_mispredict(0);
        test_preemption();
        compared++;
        if (flush_count !== 32'd3 || stall_cycles !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL perf_flush_count: got %0d/%0d expected 3/0", flush_count, stall_cycles);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 0, '0, 0, '0, 0, '0);
            advance();
        end
        applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, '0);
        #1;
        compared++;
        if (stall_cycles !== 32'd10) begin
            mismatched++;
            $display("[TB] FAIL perf_stall_cycles: got %0d expected 10", stall_cycles);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_mispredict(1);
        test_priority();
        test_preemption();
        test_drain_filter();
        test_random();
`ifdef PIPE_CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
